// File: rtl/dot_accum_pkg.sv
// Shared types and default sizing for the multiplier / dot-product datapath.
package dot_accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_PW  = 16;
  localparam int unsigned DEF_AW  = 24;
  localparam int unsigned DEF_LEN = 8;

endpackage

// File: rtl/dot_accum_sat_add.sv
// Combinational unsigned adder that clamps to all-ones on carry-out.
module sat_add #(
  parameter int unsigned PW = 16,
  parameter int unsigned AW = 24
) (
  input  logic [AW-1:0] a_i,
  input  logic [PW-1:0] b_i,
  output logic [AW-1:0] sum_o,
  output logic          sat_o
);

  logic [AW:0] wide;

  // Add at AW+1 bits so the carry is visible, then clamp.
  always_comb begin
    wide  = {1'b0, a_i} + {{(AW + 1 - PW){1'b0}}, b_i};
    sat_o = wide[AW];
    sum_o = wide[AW] ? '1 : wide[AW-1:0];
  end

endmodule

// File: rtl/dot_accum.sv
// Accumulates LEN unsigned products into one saturating dot-product result
// and presents it on a valid/ready handshake.
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int unsigned PW  = DEF_PW,
  parameter int unsigned AW  = DEF_AW,
  parameter int unsigned LEN = DEF_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_valid,
  input  logic [PW-1:0] P,
  output logic          p_ready,
  input  logic          clr,
  output logic [AW-1:0] acc_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ovf,
  output logic          busy
);

  localparam int unsigned CW = $clog2(LEN + 1);

  state_e          state_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            ovf_q;
  logic [AW-1:0]   sum;
  logic            sat;
  logic            accept;

  sat_add #(
    .PW (PW),
    .AW (AW)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (P),
    .sum_o (sum),
    .sat_o (sat)
  );

  // Handshake and count-increment decode; clr blocks any product that cycle.
  always_comb begin
    p_ready = (state_q != DONE) && !clr;
    accept  = p_valid && p_ready;
    cnt_d   = cnt_q + CW'(1);
  end

  assign acc_out   = acc_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACC);
  assign ovf       = ovf_q;

  // Run state machine: rst over clr over normal accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q   <= AW'(P);
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(1);
            state_q <= (LEN == 1) ? DONE : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_q <= sum;
            ovf_q <= ovf_q | sat;
            cnt_q <= cnt_d;
            if (cnt_d == CW'(LEN)) state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum: a 24-bit and a 17-bit accumulator share stimulus.
module tb_dot_accum;

  localparam int unsigned PW  = 16;
  localparam int unsigned LEN = 4;

  logic          clk = 1'b0;
  logic          rst, p_valid, clr, out_ready;
  logic [PW-1:0] P;

  logic          pr24, ov24, ovf24, busy24;
  logic [23:0]   acc24;
  logic          pr17, ov17, ovf17, busy17;
  logic [16:0]   acc17;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  dot_accum #(.PW(PW), .AW(24), .LEN(LEN)) u24 (
    .clk(clk), .rst(rst), .p_valid(p_valid), .P(P), .p_ready(pr24), .clr(clr),
    .acc_out(acc24), .out_valid(ov24), .out_ready(out_ready), .ovf(ovf24), .busy(busy24)
  );

  dot_accum #(.PW(PW), .AW(17), .LEN(LEN)) u17 (
    .clk(clk), .rst(rst), .p_valid(p_valid), .P(P), .p_ready(pr17), .clr(clr),
    .acc_out(acc17), .out_valid(ov17), .out_ready(out_ready), .ovf(ovf17), .busy(busy17)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [PW-1:0] v);
    p_valid = 1'b1;
    P       = v;
    step();
    p_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; p_valid = 1'b0; clr = 1'b0; out_ready = 1'b0; P = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_acc", acc24, 0);
    chk("rst_valid", ov24, 0);
    chk("rst_ovf", ovf24, 0);
    chk("rst_busy", busy24, 0);
    chk("rst_pready", pr24, 1);

    // Back-to-back run 10,20,30,40.
    out_ready = 1'b1;
    p_valid = 1'b1;
    P = 10; step();
    chk("b2b_busy1", busy24, 1);
    P = 20; step();
    P = 30; step();
    P = 40; step();
    p_valid = 1'b0;
    chk("b2b_valid", ov24, 1);
    chk("b2b_acc", acc24, 100);
    chk("b2b_ovf", ovf24, 0);
    chk("b2b_pready_done", pr24, 0);
    step();
    chk("b2b_valid_drop", ov24, 0);

    // Same run with two idle cycles between products.
    feed(10); step(); chk("gap_busy_a", busy24, 1); step(); chk("gap_busy_b", busy24, 1);
    feed(20); step(); chk("gap_busy_c", busy24, 1); step(); chk("gap_novalid", ov24, 0);
    feed(30); step(); step();
    feed(40);
    chk("gap_valid", ov24, 1);
    chk("gap_acc", acc24, 100);
    step();
    chk("gap_valid_drop", ov24, 0);

    // Saturation on the 17-bit instance; 24-bit holds the exact sum.
    feed(16'hFFFF); feed(16'hFFFF);
    chk("sat_acc17_2", acc17, 131070);
    chk("sat_ovf17_2", ovf17, 0);
    feed(16'hFFFF);
    chk("sat_acc17_3", acc17, 131071);
    chk("sat_ovf17_3", ovf17, 1);
    feed(16'hFFFF);
    chk("sat_valid17", ov17, 1);
    chk("sat_acc17", acc17, 131071);
    chk("sat_ovf17", ovf17, 1);
    chk("sat_acc24", acc24, 262140);
    chk("sat_ovf24", ovf24, 0);
    step();
    chk("sat_ovf17_sticky_idle", ovf17, 1);
    feed(1);
    chk("sat_ovf17_newrun", ovf17, 0);
    feed(2); feed(3); feed(4);
    chk("sat_next_acc17", acc17, 10);
    chk("sat_next_ovf17", ovf17, 0);
    chk("sat_next_valid17", ov17, 1);
    step();

    // Backpressure: hold in DONE with a product waiting.
    out_ready = 1'b0;
    feed(1); feed(2); feed(3); feed(4);
    p_valid = 1'b1; P = 99;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_pready", pr24, 0);
      chk("bp_valid", ov24, 1);
      chk("bp_acc", acc24, 10);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", ov24, 0);
    chk("bp_release_nobypass", acc24, 10);
    chk("bp_release_busy", busy24, 0);
    chk("bp_release_pready", pr24, 1);
    step();
    p_valid = 1'b0;
    chk("bp_next_accept_busy", busy24, 1);
    chk("bp_next_accept_acc", acc24, 99);
    clr = 1'b1; step(); clr = 1'b0;
    chk("bp_clr_acc", acc24, 0);

    // clr after two products, with a product presented in the same cycle.
    feed(5); feed(6);
    chk("clr_partial", acc24, 11);
    clr = 1'b1; p_valid = 1'b1; P = 7;
    #1;
    chk("clr_pready", pr24, 0);
    step();
    clr = 1'b0; p_valid = 1'b0;
    chk("clr_acc", acc24, 0);
    chk("clr_busy", busy24, 0);
    chk("clr_valid", ov24, 0);
    feed(1); feed(1); feed(1); feed(1);
    chk("clr_fresh_valid", ov24, 1);
    chk("clr_fresh_acc", acc24, 4);
    step();

    // rst mid-run, then in DONE.
    feed(3); feed(3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstmid_acc", acc24, 0);
    chk("rstmid_busy", busy24, 0);
    chk("rstmid_valid", ov24, 0);
    chk("rstmid_ovf", ovf24, 0);
    out_ready = 1'b0;
    feed(2); feed(2); feed(2); feed(2);
    chk("rstdone_pre_acc", acc24, 8);
    chk("rstdone_pre_valid", ov24, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstdone_acc", acc24, 0);
    chk("rstdone_valid", ov24, 0);
    chk("rstdone_busy", busy24, 0);
    out_ready = 1'b1;
    feed(1); feed(2); feed(3); feed(4);
    chk("rst_fresh_acc", acc24, 10);
    chk("rst_fresh_valid", ov24, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_accum.md
Name: dot_accum

Overview:
Downstream consumer of the array multiplier's product P. It accumulates a fixed-length run of LEN unsigned products into one dot-product result. It saturates on overflow and presents the result on a valid/ready output handshake. It sits between the multiplier datapath and the result-collection logic.

Parameters:
PW, 16, product input width (matches multiplier N)
AW, 24, accumulator/result width, AW >= PW
LEN, 8, products per dot product, LEN >= 1
CW, $clog2(LEN+1), count width (derived localparam, not overridable)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
p_valid  input  1  product on P is valid this cycle
P  input  PW  unsigned product from the multiplier
p_ready  output  1  block can accept a product this cycle
clr  input  1  synchronous abort of the current accumulation
acc_out  output  AW  accumulated result
out_valid  output  1  acc_out holds a completed dot product
out_ready  input  1  consumer accepts acc_out
ovf  output  1  saturation occurred in the current/held result
busy  output  1  accumulation in progress (state ACC)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, acc_out=0, cnt=0, out_valid=0, ovf=0, busy=0. rst overrides every other input, including mid-run and in DONE.
- Accept: a product is taken when p_valid && p_ready at a posedge. p_ready = (state != DONE) && !clr.
- States:
  - IDLE: on accept, acc_out=zero-extended P, ovf=0, cnt=1. Go to DONE if LEN==1, else to ACC.
  - ACC: on accept, acc_out=sat_add(acc_out, P) and cnt=cnt+1. If the new cnt==LEN, go to DONE. With no accept, hold all values.
  - DONE: out_valid=1; acc_out and ovf stable. When out_ready=1, go to IDLE; out_valid is 0 from the next cycle. No product is accepted in DONE, including in the cycle out_ready=1 (no bypass), so the next run starts the following cycle at the earliest.
- Latency: out_valid rises in the cycle after the posedge that accepts the LEN-th product.
- Saturation: the sum is computed at AW+1 bits. If the carry is set, acc_out=2^AW-1 and ovf=1. ovf is sticky until the next run starts in IDLE, or until clr/rst.
- clr: in IDLE/ACC, go to IDLE with acc_out=0, cnt=0, ovf=0; any product presented that cycle is dropped (p_ready=0). In DONE, clr also discards the result and goes to IDLE. clr has lower priority than rst.
- busy = (state==ACC).
- Gaps: p_valid may drop between products for any number of cycles; the accumulation simply holds.
- Wrap: cnt never exceeds LEN and is cleared on leaving DONE.

Decomposition:
- Package dot_accum_pkg: state enum typedef {IDLE, ACC, DONE} as a 2-bit logic type, and default PW/AW/LEN constants shared with the multiplier stage.
- Sub-module sat_add #(PW,AW): combinational saturating unsigned adder with outputs sum[AW-1:0] and sat. dot_accum instantiates it once.

Test Plan:
- LEN=4, AW=24; products 10,20,30,40 on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th accept, acc_out=100, ovf=0; out_valid=0 the next cycle.
- Same run with 2 idle cycles between products -> acc_out=100; busy=1 throughout the gaps; result timing is relative to the last accept.
- LEN=4, AW=17; four products of 16'hFFFF -> acc_out=131071, ovf=1; the next run 1,2,3,4 -> acc_out=10, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with p_valid=1 -> p_ready=0, acc_out stable, out_valid=1; then out_ready=1 -> IDLE, and the first new product is accepted the following cycle.
- clr after 2 of 4 products (values 5,6), with p_valid=1 and P=7 in the same cycle -> P=7 dropped, IDLE, acc_out=0; a fresh run 1,1,1,1 -> acc_out=4.
- rst asserted mid-run and again in DONE -> all outputs return to 0 on the next posedge; a fresh run completes correctly afterwards.
